// File: rtl/xtal_mon_pkg.sv
// ---------------------------------------------------------------------------
// xtal_mon_pkg
// Shared types and helpers for the crystal oscillator startup monitor.
//   state_e   : 3-bit FSM state encoding; also the value driven on state_o
//   in_range  : window verdict, true when min_cnt <= cnt <= max_cnt
//   is_counting : true in the states where measurement windows run
// ---------------------------------------------------------------------------
package xtal_mon_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STARTUP = 3'd1,
        ST_MEASURE = 3'd2,
        ST_READY   = 3'd3,
        ST_STANDBY = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;

    function automatic logic in_range(
        input logic [31:0] cnt,
        input logic [31:0] min_cnt,
        input logic [31:0] max_cnt
    );
        return (cnt >= min_cnt) && (cnt <= max_cnt);
    endfunction

    function automatic logic is_counting(input state_e st);
        return (st == ST_MEASURE) || (st == ST_READY);
    endfunction

endpackage

// File: rtl/xtal_edge_sync.sv
// ---------------------------------------------------------------------------
// xtal_edge_sync
// Brings the asynchronous oscillator output into the clk domain and counts
// its rising edges with a saturating counter.
//   clk, resetn : reference clock, asynchronous active-low reset
//   i_din       : raw oscillator output (asynchronous to clk)
//   i_en        : count enable
//   i_clr       : synchronous clear, wins over i_en
//   o_cnt_nxt   : count including an edge detected this cycle; this is the
//                 value the counter loads unless i_clr is high
// ---------------------------------------------------------------------------
module xtal_edge_sync #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_din,
    input  logic             i_en,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt_nxt
);

    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_dly;
    logic [CNT_W-1:0] r_cnt;
    logic             w_edge;
    logic             w_inc;

    // Two flops for metastability, a third to see the previous level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_dly;

    // Saturate rather than wrap so a runaway input never aliases into range.
    assign w_inc     = i_en & w_edge & (r_cnt != CNT_SAT);
    assign o_cnt_nxt = r_cnt + CNT_W'(w_inc);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= o_cnt_nxt;
        end
    end

endmodule

// File: rtl/xtal_osc_startup_monitor.sv
// ---------------------------------------------------------------------------
// xtal_osc_startup_monitor
// Sequences power-up of the 16 MHz crystal oscillator, waits a settle time,
// then qualifies its output by counting edges over fixed windows. clk_ok is
// high only while the measured frequency is in range; fault is sticky.
//   clk        : always-on reference clock (>= 2.5x oscillator frequency)
//   resetn     : asynchronous active-low reset
//   en_req     : software enable
//   stdby_req  : software standby request
//   xtal_dout  : oscillator output, asynchronous to clk
//   osc_ena    : oscillator enable
//   osc_stdby  : oscillator standby
//   clk_ok     : oscillator qualified and in range
//   fault      : sticky failure flag, cleared only when leaving OFF
//   meas_cnt   : edge count of the most recently completed window
//   state_o    : current FSM state (state_e encoding)
// All outputs are flops loaded from the next-state decode, so they change
// on the same edge as the state they describe.
// ---------------------------------------------------------------------------
module xtal_osc_startup_monitor
    import xtal_mon_pkg::*;
#(
    parameter int unsigned STARTUP_CYC = 65536,
    parameter int unsigned WIN_CYC     = 256,
    parameter int unsigned CNT_W       = 9,
    parameter int unsigned MIN_CNT     = 77,
    parameter int unsigned MAX_CNT     = 87,
    parameter int unsigned RETRY_MAX   = 3,
    parameter int unsigned FAIL_LIMIT  = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en_req,
    input  logic             stdby_req,
    input  logic             xtal_dout,
    output logic             osc_ena,
    output logic             osc_stdby,
    output logic             clk_ok,
    output logic             fault,
    output logic [CNT_W-1:0] meas_cnt,
    output logic [2:0]       state_o
);

    localparam int unsigned SU_W   = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
    localparam int unsigned WIN_W  = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int unsigned RTY_W  = $clog2(RETRY_MAX + 1);
    localparam int unsigned FAIL_W = $clog2(FAIL_LIMIT + 1);

    localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(STARTUP_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [SU_W-1:0]   r_su_cnt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [RTY_W-1:0]  r_retry;
    logic [FAIL_W-1:0] r_fail;

    logic              r_osc_ena;
    logic              r_osc_stdby;
    logic              r_clk_ok;
    logic              r_fault;
    logic [CNT_W-1:0]  r_meas_cnt;

    logic              w_counting;
    logic              w_win_end;
    logic              w_su_done;
    logic              w_in_range;
    logic              w_retry_exhaust;
    logic              w_fail_exhaust;
    logic [CNT_W-1:0]  w_win_edges;

    logic              w_start;
    logic              w_retry_inc;
    logic              w_fail_inc;
    logic              w_fail_clr;

    // ------------------------------------------------------------------
    // Edge counting
    // ------------------------------------------------------------------
    assign w_counting = is_counting(r_state);
    assign w_win_end  = w_counting && (r_win_cnt == WIN_LAST);
    assign w_su_done  = (r_state == ST_STARTUP) && (r_su_cnt == SU_LAST);

    // Edge counter is held at zero outside the measuring states so every
    // window, including the first one after STARTUP, starts clean.
    xtal_edge_sync #(
        .CNT_W (CNT_W)
    ) u_edge_sync (
        .clk       (clk),
        .resetn    (resetn),
        .i_din     (xtal_dout),
        .i_en      (w_counting),
        .i_clr     (w_win_end | ~w_counting),
        .o_cnt_nxt (w_win_edges)
    );

    // Verdict uses the count including an edge seen in the last cycle.
    assign w_in_range      = in_range(32'(w_win_edges), 32'(MIN_CNT), 32'(MAX_CNT));
    assign w_retry_exhaust = (32'(r_retry) + 32'd1) >= 32'(RETRY_MAX);
    assign w_fail_exhaust  = (32'(r_fail) + 32'd1) >= 32'(FAIL_LIMIT);

    // ------------------------------------------------------------------
    // Next-state decode. en_req low beats everything, then stdby_req,
    // then window verdicts.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_retry_inc = 1'b0;
        w_fail_inc  = 1'b0;
        w_fail_clr  = 1'b0;

        if (!en_req) begin
            w_state_nxt = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_STARTUP;
                    w_start     = 1'b1;
                end
                ST_STARTUP: begin
                    if (stdby_req) begin
                        w_state_nxt = ST_STANDBY;
                    end else if (w_su_done) begin
                        w_state_nxt = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (stdby_req) begin
                        w_state_nxt = ST_STANDBY;
                    end else if (w_win_end) begin
                        if (w_in_range) begin
                            w_state_nxt = ST_READY;
                        end else begin
                            w_retry_inc = 1'b1;
                            w_state_nxt = w_retry_exhaust ? ST_FAULT : ST_STARTUP;
                        end
                    end
                end
                ST_READY: begin
                    if (stdby_req) begin
                        w_state_nxt = ST_STANDBY;
                    end else if (w_win_end) begin
                        if (w_in_range) begin
                            w_fail_clr = 1'b1;
                        end else begin
                            w_fail_inc = 1'b1;
                            if (w_fail_exhaust) begin
                                w_state_nxt = ST_FAULT;
                            end
                        end
                    end
                end
                ST_STANDBY: begin
                    if (!stdby_req) begin
                        w_state_nxt = ST_STARTUP;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_su_cnt <= '0;
        end else if ((r_state == ST_STARTUP) && !w_su_done) begin
            r_su_cnt <= r_su_cnt + 1'b1;
        end else begin
            r_su_cnt <= '0;
        end
    end

    // Window counter restarts on the cycle after a window end.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_win_cnt <= '0;
        end else if (w_counting && !w_win_end) begin
            r_win_cnt <= r_win_cnt + 1'b1;
        end else begin
            r_win_cnt <= '0;
        end
    end

    // Retry count survives STANDBY; only a fresh enable from OFF clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_retry <= '0;
        end else if (w_start) begin
            r_retry <= '0;
        end else if (w_retry_inc) begin
            r_retry <= r_retry + 1'b1;
        end
    end

    // Consecutive bad windows only mean something while staying in READY.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fail <= '0;
        end else if ((w_state_nxt != ST_READY) || w_fail_clr) begin
            r_fail <= '0;
        end else if (w_fail_inc) begin
            r_fail <= r_fail + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_osc_ena   <= 1'b0;
            r_osc_stdby <= 1'b0;
            r_clk_ok    <= 1'b0;
            r_fault     <= 1'b0;
            r_meas_cnt  <= '0;
        end else begin
            r_osc_ena   <= (w_state_nxt == ST_STARTUP) || (w_state_nxt == ST_MEASURE) ||
                           (w_state_nxt == ST_READY)   || (w_state_nxt == ST_STANDBY);
            r_osc_stdby <= (w_state_nxt == ST_STANDBY);
            r_clk_ok    <= (w_state_nxt == ST_READY);
            if (w_start) begin
                r_fault <= 1'b0;
            end else if (w_state_nxt == ST_FAULT) begin
                r_fault <= 1'b1;
            end
            if (w_win_end) begin
                r_meas_cnt <= w_win_edges;
            end
        end
    end

    assign osc_ena   = r_osc_ena;
    assign osc_stdby = r_osc_stdby;
    assign clk_ok    = r_clk_ok;
    assign fault     = r_fault;
    assign meas_cnt  = r_meas_cnt;
    assign state_o   = r_state;

endmodule

// File: tb/tb_xtal_osc_startup_monitor.sv
// ---------------------------------------------------------------------------
// tb_xtal_osc_startup_monitor
// Bench for the oscillator startup monitor with a 50 MHz reference clock and
// a shortened settle time. The oscillator is modelled as a square wave that
// only toggles while osc_ena is high and dout_run is set. All half periods
// are multiples of 1.25 ns on a 3 ns offset, so oscillator edges never land
// on a clk edge.
// ---------------------------------------------------------------------------
module tb_xtal_osc_startup_monitor;
    import xtal_mon_pkg::*;

    localparam int STARTUP_CYC = 64;
    localparam int WIN_CYC     = 256;
    localparam int CNT_W       = 9;
    localparam int MIN_CNT     = 77;
    localparam int MAX_CNT     = 87;
    localparam int RETRY_MAX   = 3;
    localparam int FAIL_LIMIT  = 2;

    logic             clk;
    logic             resetn;
    logic             en_req;
    logic             stdby_req;
    logic             xtal_dout;
    logic             osc_ena;
    logic             osc_stdby;
    logic             clk_ok;
    logic             fault;
    logic [CNT_W-1:0] meas_cnt;
    logic [2:0]       state_o;

    real  half_ns;
    logic dout_run;
    int   n_tests;
    int   n_fail;

    typedef struct {
        string name;
        real   half_ns;
        logic  run;
        int    lo;
        int    hi;
        logic  exp_ready;
    } vec_t;

    vec_t vecs[4];

    xtal_osc_startup_monitor #(
        .STARTUP_CYC (STARTUP_CYC),
        .WIN_CYC     (WIN_CYC),
        .CNT_W       (CNT_W),
        .MIN_CNT     (MIN_CNT),
        .MAX_CNT     (MAX_CNT),
        .RETRY_MAX   (RETRY_MAX),
        .FAIL_LIMIT  (FAIL_LIMIT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en_req    (en_req),
        .stdby_req (stdby_req),
        .xtal_dout (xtal_dout),
        .osc_ena   (osc_ena),
        .osc_stdby (osc_stdby),
        .clk_ok    (clk_ok),
        .fault     (fault),
        .meas_cnt  (meas_cnt),
        .state_o   (state_o)
    );

    // clock block: 50 MHz
    initial begin
        clk = 1'b0;
        forever #10ns clk = ~clk;
    end

    // oscillator model
    initial begin
        xtal_dout = 1'b0;
        #3ns;
        forever begin
            #(half_ns * 1ns);
            if (dout_run && osc_ena) xtal_dout = ~xtal_dout;
            else                     xtal_dout = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1ns;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // From any state: restart from OFF and run to the first READY cycle.
    task automatic bring_up(input string name);
        en_req = 1'b0;
        tick(1);
        en_req = 1'b1;
        tick(1);
        tick(STARTUP_CYC + WIN_CYC - 1);
        chk({name, "_last_win_cycle"}, int'(state_o), int'(ST_MEASURE));
        tick(1);
        chk({name, "_ready"}, int'(state_o), int'(ST_READY));
        chk({name, "_clk_ok"}, int'(clk_ok), 1);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        en_req    = 1'b0;
        stdby_req = 1'b0;
        dout_run  = 1'b0;
        half_ns   = 31.25;

        vecs[0] = '{"nominal_16m", 31.25, 1'b1, 81, 82, 1'b1};
        vecs[1] = '{"dead_xtal",   31.25, 1'b0,  0,  0, 1'b0};
        vecs[2] = '{"low_12m",     41.25, 1'b1, 61, 64, 1'b0};
        vecs[3] = '{"high_30m",    16.25, 1'b1, 88, 511, 1'b0};

        // reset state
        tick(3);
        chk("rst_osc_ena",   int'(osc_ena), 0);
        chk("rst_osc_stdby", int'(osc_stdby), 0);
        chk("rst_clk_ok",    int'(clk_ok), 0);
        chk("rst_fault",     int'(fault), 0);
        chk("rst_meas_cnt",  int'(meas_cnt), 0);
        chk("rst_state",     int'(state_o), int'(ST_OFF));
        resetn = 1'b1;
        tick(2);
        chk("idle_off", int'(state_o), int'(ST_OFF));

        // table-driven start attempts at several oscillator frequencies
        for (int v = 0; v < 4; v++) begin
            int rounds;
            half_ns  = vecs[v].half_ns;
            dout_run = vecs[v].run;
            en_req   = 1'b0;
            tick(1);
            chk({vecs[v].name, "_off"}, int'(state_o), int'(ST_OFF));
            en_req = 1'b1;
            tick(1);
            chk({vecs[v].name, "_ena"}, int'(osc_ena), 1);
            chk({vecs[v].name, "_fault_clr"}, int'(fault), 0);
            chk({vecs[v].name, "_startup"}, int'(state_o), int'(ST_STARTUP));
            rounds = vecs[v].exp_ready ? 1 : RETRY_MAX;
            for (int r = 0; r < rounds; r++) begin
                tick(STARTUP_CYC - 1);
                chk({vecs[v].name, "_settling"}, int'(state_o), int'(ST_STARTUP));
                tick(1);
                chk({vecs[v].name, "_measure"}, int'(state_o), int'(ST_MEASURE));
                tick(WIN_CYC - 1);
                chk({vecs[v].name, "_no_ok_early"}, int'(clk_ok), 0);
                tick(1);
                chk_rng({vecs[v].name, "_meas_cnt"}, int'(meas_cnt), vecs[v].lo, vecs[v].hi);
                if (vecs[v].exp_ready) begin
                    chk({vecs[v].name, "_ready"}, int'(state_o), int'(ST_READY));
                    chk({vecs[v].name, "_clk_ok"}, int'(clk_ok), 1);
                end else if (r < rounds - 1) begin
                    chk({vecs[v].name, "_retry"}, int'(state_o), int'(ST_STARTUP));
                    chk({vecs[v].name, "_no_fault_yet"}, int'(fault), 0);
                end else begin
                    chk({vecs[v].name, "_fault_state"}, int'(state_o), int'(ST_FAULT));
                    chk({vecs[v].name, "_fault"}, int'(fault), 1);
                    chk({vecs[v].name, "_ena_off"}, int'(osc_ena), 0);
                    chk({vecs[v].name, "_clk_ok_off"}, int'(clk_ok), 0);
                end
            end
            if (!vecs[v].exp_ready) begin
                stdby_req = 1'b1;
                tick(2);
                chk({vecs[v].name, "_stdby_ignored"}, int'(state_o), int'(ST_FAULT));
                chk({vecs[v].name, "_no_stdby"}, int'(osc_stdby), 0);
                stdby_req = 1'b0;
            end
            en_req = 1'b0;
            tick(1);
            chk({vecs[v].name, "_to_off"}, int'(state_o), int'(ST_OFF));
            chk({vecs[v].name, "_fault_sticky"}, int'(fault), vecs[v].exp_ready ? 0 : 1);
            chk({vecs[v].name, "_off_ena"}, int'(osc_ena), 0);
        end

        half_ns  = 31.25;
        dout_run = 1'b1;

        // loss in READY, with a good window in between resetting the fail count
        bring_up("loss");
        dout_run = 1'b0;
        tick(WIN_CYC);
        chk("loss_w1_state", int'(state_o), int'(ST_READY));
        chk("loss_w1_ok", int'(clk_ok), 1);
        chk_rng("loss_w1_cnt", int'(meas_cnt), 0, 1);
        dout_run = 1'b1;
        tick(WIN_CYC);
        chk("loss_w2_state", int'(state_o), int'(ST_READY));
        chk_rng("loss_w2_cnt", int'(meas_cnt), MIN_CNT, MAX_CNT);
        dout_run = 1'b0;
        tick(WIN_CYC);
        chk("loss_w3_state", int'(state_o), int'(ST_READY));
        chk("loss_w3_ok", int'(clk_ok), 1);
        tick(WIN_CYC - 1);
        chk("loss_w4_ok_before", int'(clk_ok), 1);
        tick(1);
        chk("loss_w4_state", int'(state_o), int'(ST_FAULT));
        chk("loss_w4_ok", int'(clk_ok), 0);
        chk("loss_w4_fault", int'(fault), 1);
        chk("loss_w4_cnt", int'(meas_cnt), 0);
        chk("loss_w4_ena", int'(osc_ena), 0);
        dout_run = 1'b1;

        // standby from READY and recovery
        bring_up("stby");
        stdby_req = 1'b1;
        tick(1);
        chk("stby_state", int'(state_o), int'(ST_STANDBY));
        chk("stby_osc_stdby", int'(osc_stdby), 1);
        chk("stby_clk_ok", int'(clk_ok), 0);
        chk("stby_osc_ena", int'(osc_ena), 1);
        tick(20);
        chk("stby_hold", int'(state_o), int'(ST_STANDBY));
        stdby_req = 1'b0;
        tick(1);
        chk("stby_release", int'(state_o), int'(ST_STARTUP));
        chk("stby_release_stdby", int'(osc_stdby), 0);
        tick(STARTUP_CYC + WIN_CYC - 1);
        chk("stby_ok_early", int'(clk_ok), 0);
        tick(1);
        chk("stby_ok_again", int'(clk_ok), 1);

        // en_req low on the exact cycle an in-range window completes
        en_req = 1'b0;
        tick(1);
        en_req = 1'b1;
        tick(1);
        tick(STARTUP_CYC + WIN_CYC - 1);
        chk("prio_en_last_cycle", int'(state_o), int'(ST_MEASURE));
        en_req = 1'b0;
        tick(1);
        chk("prio_en_off", int'(state_o), int'(ST_OFF));
        chk("prio_en_clk_ok", int'(clk_ok), 0);
        chk("prio_en_ena", int'(osc_ena), 0);
        stdby_req = 1'b1;
        tick(2);
        chk("prio_off_stdby_ignored", int'(osc_stdby), 0);
        stdby_req = 1'b0;

        // stdby_req on the verdict cycle
        en_req = 1'b1;
        tick(1);
        tick(STARTUP_CYC + WIN_CYC - 1);
        stdby_req = 1'b1;
        tick(1);
        chk("prio_stby_state", int'(state_o), int'(ST_STANDBY));
        chk("prio_stby_clk_ok", int'(clk_ok), 0);
        chk("prio_stby_osc_stdby", int'(osc_stdby), 1);
        stdby_req = 1'b0;
        tick(1);
        chk("prio_stby_release", int'(state_o), int'(ST_STARTUP));

        // asynchronous reset mid-MEASURE
        tick(STARTUP_CYC + 100);
        chk("arst_in_measure", int'(state_o), int'(ST_MEASURE));
        chk("arst_ena_before", int'(osc_ena), 1);
        resetn = 1'b0;
        #2ns;
        chk("arst_osc_ena",   int'(osc_ena), 0);
        chk("arst_osc_stdby", int'(osc_stdby), 0);
        chk("arst_clk_ok",    int'(clk_ok), 0);
        chk("arst_fault",     int'(fault), 0);
        chk("arst_meas_cnt",  int'(meas_cnt), 0);
        chk("arst_state",     int'(state_o), int'(ST_OFF));
        tick(2);
        resetn = 1'b1;
        en_req = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
